sprite_anim_sequencer: RTL

Producer side of the sprite address path. Generates the timing and state signals that the sprite priority/address stage consumes:
- Pac-Man direction requests, with 3'b111 meaning "hold".
- Per-sprite animation phase counters.
- The death countdown and dying flag.
- Lives/respawn/game-over control.

It sits between the keyboard/collision logic and the sprite address stage. It advances once per frame, on the vertical sync edge.

---
 rtl/sprite_anim_pkg.sv | 34 +++
 rtl/sprite_anim_sequencer_anim_counter.sv | 25 ++
 rtl/sprite_anim_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/sprite_anim_pkg.sv
// Shared types and constants for the sprite animation sequencer.
// Direction codes, HID keycodes and the life-cycle state encoding.
package sprite_anim_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'b000,
    DIR_LEFT  = 3'b001,
    DIR_DOWN  = 3'b010,
    DIR_RIGHT = 3'b011,
    DIR_HOLD  = 3'b111
  } dir_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {
    ALIVE,
    DYING,
    GAME_OVER
  } anim_state_t;

  function automatic dir_t decode_key(input logic [7:0] key);
    case (key)
      KEY_W:   return DIR_UP;
      KEY_A:   return DIR_LEFT;
      KEY_S:   return DIR_DOWN;
      KEY_D:   return DIR_RIGHT;
      default: return DIR_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/sprite_anim_sequencer_anim_counter.sv
// Wrapping animation phase counter: counts 0..PERIOD-1 on en, clr forces 0.
// clr has priority over en; updates take effect on the next Clk edge.
module anim_counter #(
  parameter int PERIOD = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       en,
  input  logic       clr,
  output logic [6:0] count
);

  localparam logic [6:0] LAST = 7'(PERIOD - 1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= 7'd0;
    end else if (clr) begin
      count <= 7'd0;
    end else if (en) begin
      count <= (count == LAST) ? 7'd0 : count + 7'd1;
    end
  end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Per-frame sprite animation, death countdown and lives control.
// Advances on a synchronized vsync rising edge; pac_hit is sampled every Clk.
module sprite_anim_sequencer
  import sprite_anim_pkg::*;
#(
  parameter int PAC_ANIM_PERIOD   = 6,
  parameter int GHOST_ANIM_PERIOD = 6,
  parameter int DEATH_START       = 100,
  parameter int LIVES_INIT        = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       pac_moving,
  input  logic [3:0] ghost_active,
  input  logic       pac_hit,
  output logic [2:0] direction_out,
  output logic [6:0] animation_count,
  output logic [6:0] red_ghost_animation_count,
  output logic [6:0] orange_ghost_animation_count,
  output logic [6:0] cyan_ghost_animation_count,
  output logic [6:0] pink_ghost_animation_count,
  output logic [6:0] death_time,
  output logic       dying,
  output logic       respawn,
  output logic [1:0] lives,
  output logic       game_over
);

  logic [2:0]  frame_sync;
  logic        tick;
  anim_state_t state;
  dir_t        dir_q;
  logic        alive_tick;
  logic        clr_counts;
  logic [6:0]  ghost_count [4];

  // [0],[1] synchronize, [2] holds the previous synchronized level for edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_sync <= 3'b000;
    else          frame_sync <= {frame_sync[1:0], frame_clk};
  end

  assign tick = frame_sync[1] & ~frame_sync[2];

  // A hit in the same cycle as a tick takes the transition and freezes counters
  assign alive_tick = (state == ALIVE) && tick && !pac_hit;
  assign clr_counts = (state == DYING) && tick && (death_time == 7'd0) && (lives > 2'd1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ALIVE;
      dir_q      <= DIR_HOLD;
      death_time <= 7'd0;
      dying      <= 1'b0;
      respawn    <= 1'b0;
      lives      <= 2'(LIVES_INIT);
      game_over  <= 1'b0;
    end else begin
      respawn <= 1'b0;
      dir_q   <= (state == ALIVE && !pac_hit) ? decode_key(keycode) : DIR_HOLD;
      case (state)
        ALIVE: begin
          if (pac_hit) begin
            state      <= DYING;
            death_time <= 7'(DEATH_START);
            dying      <= 1'b1;
          end
        end
        DYING: begin
          if (tick) begin
            if (death_time != 7'd0) begin
              death_time <= death_time - 7'd1;
            end else if (lives > 2'd1) begin
              lives   <= lives - 2'd1;
              respawn <= 1'b1;
              dying   <= 1'b0;
              state   <= ALIVE;
            end else begin
              lives     <= 2'd0;
              dying     <= 1'b0;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign direction_out = dir_q;

  anim_counter #(.PERIOD(PAC_ANIM_PERIOD)) u_pac_counter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .en      (alive_tick && pac_moving),
    .clr     (clr_counts),
    .count   (animation_count)
  );

  for (genvar g = 0; g < 4; g++) begin : g_ghost
    anim_counter #(.PERIOD(GHOST_ANIM_PERIOD)) u_ghost_counter (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .en      (alive_tick && ghost_active[g]),
      .clr     (clr_counts),
      .count   (ghost_count[g])
    );
  end

  assign red_ghost_animation_count    = ghost_count[0];
  assign orange_ghost_animation_count = ghost_count[1];
  assign cyan_ghost_animation_count   = ghost_count[2];
  assign pink_ghost_animation_count   = ghost_count[3];

endmodule
